axi4_lite_write_arbiter: RTL
============================

Name: axi4_lite_write_arbiter

Overview:
- Two-requester arbiter for one AXI4-lite write slave port (64-bit addr/data, 8-bit strobe).
- Sits between the write requesters (e.g. LSU store path and a debug/DMA writer) and the single write slave.
- Grants one master per transaction and holds the grant from AW through the B handshake, then re-arbitrates.
- Round-robin by default.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; strobe width is DATA_W/8

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- m_aw_addr  input  2*ADDR_W  master AW address; [ADDR_W-1:0]=m0
- m_aw_valid  input  2  per-master AW valid
- m_aw_ready  output  2  per-master AW ready
- m_w_data  input  2*DATA_W  master write data
- m_w_strb  input  2*DATA_W/8  master write strobes
- m_w_valid  input  2  per-master W valid
- m_w_ready  output  2  per-master W ready
- m_b_resp  output  4  per-master response, 2 bits each
- m_b_valid  output  2  per-master B valid
- m_b_ready  input  2  per-master B ready
- s_aw_addr  output  ADDR_W  to slave
- s_aw_valid  output  1  to slave
- s_aw_ready  input  1  from slave
- s_w_data  output  DATA_W  to slave
- s_w_strb  output  DATA_W/8  to slave
- s_w_valid  output  1  to slave
- s_w_ready  input  1  from slave
- s_b_resp  input  2  from slave
- s_b_valid  input  1  from slave
- s_b_ready  output  1  to slave
- grant  output  1  index of the master currently owning the slave; valid when busy=1
- busy  output  1  transaction in progress (state != IDLE)

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP. State, grant and rr_ptr are registered; all channel outputs are combinational muxes of (state, grant).
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, grant=0, rr_ptr=0 (master 0 preferred first).
  - All outputs are 0 from the following cycle.
  - Any in-flight transaction is abandoned with no response to the master.
- IDLE:
  - Idles when m_aw_valid==0.
  - One master valid: that master is granted.
  - Both valid: grant=rr_ptr.
  - On grant: register grant and go to ADDR. Nothing is forwarded in the IDLE cycle, so s_aw_valid rises 1 cycle after m_aw_valid is seen.
- ADDR:
  - s_aw_valid=m_aw_valid[grant]; s_aw_addr=granted address.
  - m_aw_ready[grant]=s_aw_ready.
  - On s_aw_valid&s_aw_ready go to DATA.
- DATA:
  - s_w_valid/data/strb come from the granted master; m_w_ready[grant]=s_w_ready.
  - On s_w_valid&s_w_ready go to RESP.
  - A master may raise w_valid before AW completes; it is not accepted until DATA.
- RESP:
  - m_b_valid[grant]=s_b_valid; m_b_resp[grant]=s_b_resp; s_b_ready=m_b_ready[grant].
  - On s_b_valid&s_b_ready go to IDLE and set rr_ptr=~grant.
- Non-granted master, or any master when state does not match the channel: ready=0, b_valid=0, b_resp=0.
- Slave outputs outside their state: valid=0, s_b_ready=0. s_aw_addr, s_w_data and s_w_strb always show the granted master's values.
- The losing master's AW stays pending, never dropped. It is served the next IDLE, since rr_ptr now favours it.
- Minimum transaction length: 4 cycles (IDLE, ADDR, DATA, RESP each 1 cycle with a zero-wait slave). A back-to-back request re-enters arbitration in IDLE, so the gap between transactions is 1 cycle.
- Handshake latency through the block is zero: ready and valid are combinational pass-through within a state.

Optional Feature:
- AXI_WR_ARB_FIXED_PRIO_EN
  - Defined: master 0 always wins simultaneous requests in IDLE; rr_ptr is removed.
  - Undefined: round-robin as above.

Decomposition:
- Shared package axi4_lite_pkg:
  - State localparams (IDLE/ADDR/DATA/RESP, 2-bit).
  - RESP_OKAY=2'b00.
  - ADDR_W/DATA_W defaults.
- One natural sub-module, axi_rr_arbiter2: pure next-grant selection (req[1:0], rr_ptr → grant, any_req). The FSM and muxing stay in the top.

Test Plan:
- Single master: m0 writes addr 0x8000_0010, data 0xDEAD_BEEF, strb 0xFF.
  - Required: s_aw_valid 1 cycle after request, data/strb pass through, grant=0.
  - Required: m_b_valid[0] with resp 00; m_*[1] ready/valid stay 0 throughout.
- Simultaneous: both masters request from reset.
  - Required: m0 served first, then m1 (0x8000_0020).
  - Required: a third simultaneous round is served by m0 again (alternation 0,1,0).
- Slave backpressure: s_aw_ready delayed 3 cycles, s_w_ready 2 cycles, s_b_valid 5 cycles.
  - Required: state holds each time, no duplicate handshake; master sees exactly one aw, w and b handshake.
- Early W: m1 asserts w_valid 2 cycles before aw_valid.
  - Required: m_w_ready[1]=0 until state DATA; the written data equals m1's data.
- Reset in DATA state.
  - Required: next cycle all valid/ready outputs 0, busy=0.
  - Required: a new m1 request then completes normally with grant=1.
- With AXI_WR_ARB_FIXED_PRIO_EN defined, both masters requesting continuously.
  - Required: m0 granted every transaction; m1 is granted only after m0 drops aw_valid.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-lite write arbiter slice.
// Write FSM state encoding, default bus widths and the OKAY response code.
package axi4_lite_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/axi_rr_arbiter2.sv
// Two-way next-grant selection: a lone requester wins outright,
// simultaneous requests are resolved by the round-robin pointer.
module axi_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       grant,
  output logic       any_req
);

  always_comb begin
    any_req = |req;
    grant   = 1'b0;
    if (req == 2'b11) begin
      grant = rr_ptr;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// Two-master AXI4-lite write arbiter; one grant held from AW through B.
// Define AXI_WR_ARB_FIXED_PRIO_EN to make master 0 win every tie instead of round-robin.
module axi4_lite_write_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*ADDR_W-1:0]   m_aw_addr,
  input  logic [1:0]            m_aw_valid,
  output logic [1:0]            m_aw_ready,
  input  logic [2*DATA_W-1:0]   m_w_data,
  input  logic [2*DATA_W/8-1:0] m_w_strb,
  input  logic [1:0]            m_w_valid,
  output logic [1:0]            m_w_ready,
  output logic [3:0]            m_b_resp,
  output logic [1:0]            m_b_valid,
  input  logic [1:0]            m_b_ready,
  output logic [ADDR_W-1:0]     s_aw_addr,
  output logic                  s_aw_valid,
  input  logic                  s_aw_ready,
  output logic [DATA_W-1:0]     s_w_data,
  output logic [DATA_W/8-1:0]   s_w_strb,
  output logic                  s_w_valid,
  input  logic                  s_w_ready,
  input  logic [1:0]            s_b_resp,
  input  logic                  s_b_valid,
  output logic                  s_b_ready,
  output logic                  grant,
  output logic                  busy
);

  localparam int STRB_W = DATA_W / 8;

  wr_state_e state_q, state_d;
  logic      grant_q, grant_d;
  logic      arb_grant;
  logic      arb_any;

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
  axi_rr_arbiter2 u_arb (
    .req     (m_aw_valid),
    .rr_ptr  (1'b0),
    .grant   (arb_grant),
    .any_req (arb_any)
  );
`else
  logic rr_ptr_q, rr_ptr_d;

  axi_rr_arbiter2 u_arb (
    .req     (m_aw_valid),
    .rr_ptr  (rr_ptr_q),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Payload buses always follow the current owner; only valid/ready are gated by state.
  assign s_aw_addr = grant_q ? m_aw_addr[2*ADDR_W-1:ADDR_W] : m_aw_addr[ADDR_W-1:0];
  assign s_w_data  = grant_q ? m_w_data[2*DATA_W-1:DATA_W]  : m_w_data[DATA_W-1:0];
  assign s_w_strb  = grant_q ? m_w_strb[2*STRB_W-1:STRB_W]  : m_w_strb[STRB_W-1:0];
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    m_aw_ready = 2'b00;
    m_w_ready  = 2'b00;
    m_b_valid  = 2'b00;
    m_b_resp   = {2{RESP_OKAY}};
    s_aw_valid = 1'b0;
    s_w_valid  = 1'b0;
    s_b_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_aw_valid          = m_aw_valid[grant_q];
        m_aw_ready[grant_q] = s_aw_ready;
        if (m_aw_valid[grant_q] && s_aw_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        s_w_valid          = m_w_valid[grant_q];
        m_w_ready[grant_q] = s_w_ready;
        if (m_w_valid[grant_q] && s_w_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        m_b_valid[grant_q] = s_b_valid;
        if (grant_q) begin
          m_b_resp[3:2] = s_b_resp;
        end else begin
          m_b_resp[1:0] = s_b_resp;
        end
        s_b_ready = m_b_ready[grant_q];
        if (s_b_valid && m_b_ready[grant_q]) begin
          state_d = IDLE;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
          // The master just served loses the next tie.
          rr_ptr_d = ~grant_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
